// File: rtl/stack_seq_ctrl.sv
// Instruction sequencer for the 8-bit stack computer: fetch/decode, stack strobes, depth tracking, ALU.
// Optional macro STACK_SEQ_CTRL_SAT_EN makes ADD saturate at 0xFF and SUB clamp at 0x00.
module stack_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [7:0]                 Data_in,
  input  logic [11:0]                inst,
  input  logic [7:0]                 top,
  output logic [PC_W-1:0]            pc,
  output logic                       push,
  output logic                       pop,
  output logic [7:0]                 stack_in,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       halted,
  output logic                       Error
);

  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] FULL_LVL = DW'(DEPTH);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_PUSHD = 4'h2;
  localparam logic [3:0] OP_POP   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_DUP   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_OP2,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t      state;
  logic [11:0] ir;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  data_reg;

  logic [3:0]  opcode;
  logic [7:0]  imm;
  logic        full;
  logic        empty;
  logic        below_two;
  logic        fault;
  logic [7:0]  alu_result;
  logic [7:0]  add_result;
  logic [7:0]  sub_result;

  assign opcode    = ir[11:8];
  assign imm       = ir[7:0];
  assign full      = (depth == FULL_LVL);
  assign empty     = (depth == '0);
  assign below_two = (depth < DW'(2));

  // SUB is second-from-top minus top: op_b was below op_a on the stack.
`ifdef STACK_SEQ_CTRL_SAT_EN
  logic [8:0] sum_wide;
  logic [8:0] diff_wide;

  always_comb begin
    sum_wide   = {1'b0, op_b} + {1'b0, op_a};
    diff_wide  = {1'b0, op_b} - {1'b0, op_a};
    add_result = sum_wide[8]  ? 8'hFF : sum_wide[7:0];
    sub_result = diff_wide[8] ? 8'h00 : diff_wide[7:0];
  end
`else
  always_comb begin
    add_result = op_b + op_a;
    sub_result = op_b - op_a;
  end
`endif

  always_comb begin
    alu_result = 8'h00;
    case (opcode)
      OP_ADD:  alu_result = add_result;
      OP_SUB:  alu_result = sub_result;
      OP_AND:  alu_result = op_b & op_a;
      OP_OR:   alu_result = op_b | op_a;
      default: alu_result = 8'h00;
    endcase
  end

  // Strobes are decoded from the current state so a faulting EXEC never issues one.
  always_comb begin
    fault    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    stack_in = 8'h00;
    case (state)
      S_EXEC: begin
        case (opcode)
          OP_NOP, OP_JMP, OP_HALT: ;
          OP_PUSHI: begin
            if (full) fault = 1'b1;
            else begin
              push     = 1'b1;
              stack_in = imm;
            end
          end
          OP_PUSHD: begin
            if (full) fault = 1'b1;
            else begin
              push     = 1'b1;
              stack_in = data_reg;
            end
          end
          OP_DUP: begin
            if (full || empty) fault = 1'b1;
            else begin
              push     = 1'b1;
              stack_in = top;
            end
          end
          OP_POP, OP_JZ: begin
            if (empty) fault = 1'b1;
            else pop = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            if (below_two) fault = 1'b1;
            else pop = 1'b1;
          end
          default: fault = 1'b1;
        endcase
      end
      S_OP2: pop = 1'b1;
      S_WB: begin
        push     = 1'b1;
        stack_in = alu_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      depth    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      data_reg <= '0;
      halted   <= 1'b0;
      Error    <= 1'b0;
    end else begin
      if (write) data_reg <= Data_in;
      case (state)
        S_FETCH: begin
          ir    <= inst;
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (fault) begin
            state <= S_ERR;
            Error <= 1'b1;
          end else begin
            case (opcode)
              OP_PUSHI, OP_PUSHD, OP_DUP: begin
                depth <= depth + 1'b1;
                state <= S_FETCH;
              end
              OP_POP: begin
                depth <= depth - 1'b1;
                state <= S_FETCH;
              end
              OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                op_a  <= top;
                depth <= depth - 1'b1;
                state <= S_OP2;
              end
              OP_JMP: begin
                pc    <= PC_W'(imm);
                state <= S_FETCH;
              end
              OP_JZ: begin
                depth <= depth - 1'b1;
                if (top == 8'h00) pc <= PC_W'(imm);
                state <= S_FETCH;
              end
              OP_HALT: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
              default: state <= S_FETCH;
            endcase
          end
        end
        S_OP2: begin
          op_b  <= top;
          depth <= depth - 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          depth <= depth + 1'b1;
          state <= S_FETCH;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed bench for stack_seq_ctrl with a ROM array and a reset-shared stack model.
module tb_stack_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  Data_in = 8'h00;
  logic [11:0] inst;
  logic [7:0]  top;
  logic [7:0]  pc;
  logic        push;
  logic        pop;
  logic [7:0]  stack_in;
  logic [3:0]  depth;
  logic        halted;
  logic        Error;

  logic [11:0] rom [0:255];
  logic [7:0]  mem [0:7];
  logic [3:0]  sp;
  int          pushCount;
  int          popCount;
  int          bothCount;
  int          checks = 0;
  int          errors = 0;
  int          nCycles;

  stack_seq_ctrl #(.DEPTH(8), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .write(write), .Data_in(Data_in),
    .inst(inst), .top(top), .pc(pc), .push(push), .pop(pop),
    .stack_in(stack_in), .depth(depth), .halted(halted), .Error(Error)
  );

  always #5 clk = ~clk;

  assign inst = rom[pc];
  assign top  = (sp == 4'd0) ? 8'h00 : mem[sp - 4'd1];

  // External stack sharing the controller's reset; pulse counters clear with it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= 4'd0;
      pushCount <= 0;
      popCount  <= 0;
      bothCount <= 0;
    end else begin
      if (push) pushCount <= pushCount + 1;
      if (pop) popCount <= popCount + 1;
      if (push && pop) bothCount <= bothCount + 1;
      if (push && sp < 4'd8) begin
        mem[sp[2:0]] <= stack_in;
        sp <= sp + 4'd1;
      end else if (pop && sp > 4'd0) begin
        sp <= sp - 4'd1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic waitHalt(input int limit, output int n);
    n = 0;
    while (!halted && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    // 1: PUSHI 3, PUSHI 5, ADD, HALT
    clearRom();
    rom[0] = 12'h103; rom[1] = 12'h105; rom[2] = 12'h400; rom[3] = 12'hF00;
    reset = 1'b1;
    #1;
    checkOutput("reset_pc", pc, 0);
    checkOutput("reset_strobes", {push, pop, halted, Error}, 0);
    checkOutput("reset_depth", depth, 0);
    @(negedge clk);
    reset = 1'b0;
    waitHalt(40, nCycles);
    checkOutput("t1_halted", halted, 1);
    checkOutput("t1_cycles", nCycles, 10);
    checkOutput("t1_top", top, 8'h08);
    checkOutput("t1_depth", depth, 1);
    checkOutput("t1_pc", pc, 4);
    checkOutput("t1_error", Error, 0);
    checkOutput("t1_pushes", pushCount, 3);
    checkOutput("t1_pops", popCount, 2);

    // 2: SUB underflow and ADD overflow
    clearRom();
    rom[0] = 12'h102; rom[1] = 12'h107; rom[2] = 12'h500;
    rom[3] = 12'h1F0; rom[4] = 12'h120; rom[5] = 12'h400; rom[6] = 12'hF00;
    applyStimulus();
    waitHalt(60, nCycles);
    checkOutput("t2_cycles", nCycles, 18);
    checkOutput("t2_depth", depth, 2);
`ifdef STACK_SEQ_CTRL_SAT_EN
    checkOutput("t2_sub", mem[0], 8'h00);
    checkOutput("t2_add", top, 8'hFF);
`else
    checkOutput("t2_sub", mem[0], 8'hFB);
    checkOutput("t2_add", top, 8'h10);
`endif

    // 3: POP on empty stack
    clearRom();
    rom[0] = 12'h300;
    applyStimulus();
    runCycles(1);
    checkOutput("t3_exec_pop", pop, 0);
    checkOutput("t3_exec_error", Error, 0);
    runCycles(1);
    checkOutput("t3_error", Error, 1);
    runCycles(20);
    checkOutput("t3_pc", pc, 1);
    checkOutput("t3_depth", depth, 0);
    checkOutput("t3_pops", popCount, 0);
    checkOutput("t3_sticky", Error, 1);

    // 4: nine PUSHI overflow an eight-entry stack
    clearRom();
    for (int i = 0; i < 9; i++) rom[i] = 12'h100 + 12'(i + 1);
    applyStimulus();
    runCycles(20);
    checkOutput("t4_pushes", pushCount, 8);
    checkOutput("t4_error", Error, 1);
    checkOutput("t4_depth", depth, 8);
    checkOutput("t4_pc", pc, 9);
    checkOutput("t4_top", top, 8'h08);
    reset = 1'b1;
    #1;
    checkOutput("t4_async_error", Error, 0);
    checkOutput("t4_async_depth", depth, 0);
    @(negedge clk);
    reset = 1'b0;

    // 5a: PUSHD 2, DUP, JZ 0 (no jump), HALT
    clearRom();
    rom[0] = 12'h200; rom[1] = 12'h800; rom[2] = 12'hA00; rom[3] = 12'hF00;
    write = 1'b1;
    Data_in = 8'h02;
    applyStimulus();
    @(negedge clk);
    write = 1'b0;
    waitHalt(40, nCycles);
    checkOutput("t5_halted", halted, 1);
    checkOutput("t5_top", top, 8'h02);
    checkOutput("t5_depth", depth, 1);
    checkOutput("t5_pc", pc, 4);
    checkOutput("t5_pops", popCount, 1);

    // 5b: Data_in=0 makes JZ loop; depth climbs until DUP overflows
    write = 1'b1;
    Data_in = 8'h00;
    applyStimulus();
    @(negedge clk);
    write = 1'b0;
    runCycles(5);
    checkOutput("t5b_pc", pc, 0);
    checkOutput("t5b_depth", depth, 1);
    checkOutput("t5b_halted", halted, 0);
    checkOutput("t5b_pushes", pushCount, 2);
    runCycles(44);
    checkOutput("t5b_error", Error, 1);
    checkOutput("t5b_depth_full", depth, 8);
    checkOutput("t5b_pc_fault", pc, 2);
    checkOutput("t5b_total_pushes", pushCount, 15);
    checkOutput("t5b_total_pops", popCount, 7);

    // 6: reset during OP2 of ADD, then rerun
    clearRom();
    rom[0] = 12'h103; rom[1] = 12'h105; rom[2] = 12'h400; rom[3] = 12'hF00;
    applyStimulus();
    runCycles(6);
    checkOutput("t6_op2_pop", pop, 1);
    checkOutput("t6_op2_depth", depth, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_pc", pc, 0);
    checkOutput("t6_async_depth", depth, 0);
    checkOutput("t6_async_flags", {push, pop, Error, halted}, 0);
    @(negedge clk);
    reset = 1'b0;
    waitHalt(40, nCycles);
    checkOutput("t6_cycles", nCycles, 10);
    checkOutput("t6_top", top, 8'h08);
    checkOutput("t6_depth", depth, 1);

    checkOutput("never_push_and_pop", bothCount, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_seq_ctrl.md
Name: stack_seq_ctrl

Overview:
Instruction sequencer for the 8-bit stack computer. It fetches 12-bit instructions from a combinational program ROM and decodes them. It drives push/pop/stack_in into the external stack memory and tracks stack depth. It also performs 8-bit ALU operations using the stack top as operand source, and raises a sticky Error on stack misuse or illegal opcodes.

Parameters:
DEPTH, 8, stack capacity in entries; the controller's full limit.
PC_W, 8, program counter width; ROM holds 2^PC_W words.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
write  input  1  load Data_in into the operand register this cycle.
Data_in  input  8  user operand for PUSHD.
inst  input  12  ROM word at address pc; combinational, valid in the same cycle.
top  input  8  current stack top; reflects push/pop one cycle after the edge.
pc  output  PC_W  program counter / ROM address.
push  output  1  stack write strobe; single cycle.
pop  output  1  stack pop strobe; single cycle.
stack_in  output  8  data written on push.
depth  output  $clog2(DEPTH+1)  current entry count.
halted  output  1  HALT executed.
Error  output  1  sticky fault flag.

Behaviour:
- Instruction format: opcode = IR[11:8], imm = IR[7:0].
- Opcodes: 0 NOP, 1 PUSHI, 2 PUSHD, 3 POP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 DUP, 9 JMP, A JZ, F HALT. B-E are illegal.
- Reset (async) values:
  - pc=0, state=FETCH, IR=0, depth=0, opA=opB=0, data_reg=0.
  - Error=0, halted=0, push=0, pop=0, stack_in=0.
  - The external stack must share the same reset.
- data_reg: loaded from Data_in when write=1, in any state including HALT/ERR. A write in the same cycle as a PUSHD EXEC is not visible; PUSHD pushes the old value.
- push, pop and stack_in are combinational decodes of state/IR/depth/top. push and pop are never both high.
- FETCH: IR<=inst; pc<=pc+1 (wraps at 2^PC_W) -> EXEC.
- EXEC:
  - NOP -> FETCH.
  - PUSHI / PUSHD / DUP:
    - Fault if depth==DEPTH, or (DUP only) if depth==0 -> ERR.
    - Otherwise push=1, stack_in = imm / data_reg / top; depth+1 -> FETCH.
  - POP: fault if depth==0 -> ERR. Otherwise pop=1, depth-1 -> FETCH.
  - ADD/SUB/AND/OR: fault if depth<2 -> ERR. Otherwise opA<=top, pop=1, depth-1 -> OP2.
  - JMP: pc<=imm -> FETCH.
  - JZ: fault if depth==0 -> ERR. Otherwise pop=1, depth-1; if top==0 then pc<=imm -> FETCH.
  - HALT -> HALT. Illegal opcode -> ERR.
- OP2: opB<=top, pop=1, depth-1 -> WB.
- WB: push=1, stack_in = opB op opA (SUB = opB - opA, i.e. second minus top); depth+1 -> FETCH.
- ALU cycle count: binary ops take 4 cycles including fetch; all other instructions take 2.
- Arithmetic: 8-bit, modulo 256; carry/borrow discarded.
- HALT state: halted=1; pc frozen; no strobes; exit only by reset.
- ERR state:
  - Error=1 from the cycle after the faulting EXEC.
  - pc, depth and the stack are untouched by the faulting instruction; no strobes are issued.
  - Exit only by reset.
- Reset mid-operation (e.g. in OP2/WB) aborts the instruction immediately. Partial pops are discarded because the stack resets too.

Optional Feature:
- Macro: STACK_SEQ_CTRL_SAT_EN.
- Defined: ADD saturates at 0xFF and SUB clamps at 0x00.
- Undefined: both wrap modulo 256.
- AND, OR and all sequencing are identical either way.

Test Plan:
1. ROM: PUSHI 3, PUSHI 5, ADD, HALT -> top=8, depth=1, halted=1, pc=4, Error=0; ADD spans 4 cycles with exactly two pop pulses and one push pulse.
2. ROM: PUSHI 2, PUSHI 7, SUB -> top=0xFB (0x00 with STACK_SEQ_CTRL_SAT_EN); PUSHI 0xF0, PUSHI 0x20, ADD -> 0x10 (0xFF with SAT).
3. ROM: POP at pc 0 on an empty stack -> no pop pulse, Error=1 one cycle after EXEC, pc stays 1, depth stays 0 for 20 further cycles.
4. DEPTH=8, nine consecutive PUSHI -> eight push pulses, Error on the ninth, depth=8.
5. write=1, Data_in=2 during and just after reset, then ROM: PUSHD, DUP, JZ 0x00, HALT -> top=2, JZ pops without jumping, depth=1, halted=1. Repeat with Data_in=0 -> JZ jumps to 0, so the program loops.
6. Assert reset during OP2 of ADD -> pc=0, depth=0, push/pop/Error/halted=0 immediately without waiting for a clock edge; the program reruns correctly after release.
